run_controller: RTL and testbench
=================================

Name: run_controller

Overview:
- Execution sequencer between the front-panel controls (next, run, speedRun, nowCode) and the CPU.
- Converts button presses into single-cycle CPU step enables, in single-step, slow continuous or fast continuous mode.
- Honours a CPU halt request.
- Provides a display-view toggle and a retired-step counter for the monitor outputs.

Parameters:
- DIV_W, 26: prescaler counter width.
- SLOW_DIV, 25000000: clocks between steps in RUN mode; must be ≥1 and < 2^DIV_W.
- FAST_DIV, 250000: clocks between steps in FAST mode; must be ≥1 and < 2^DIV_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- next  in  1  single-step button, asynchronous level.
- run  in  1  run/stop toggle button, asynchronous level.
- speedRun  in  1  fast-run toggle button, asynchronous level.
- nowCode  in  1  display-view toggle button, asynchronous level.
- cpu_halt  in  1  CPU halt request, synchronous level.
- pc  in  8  CPU program counter, used only by the breakpoint feature.
- address  in  8  breakpoint address, used only by the breakpoint feature.
- step_en  out  1  one-clock CPU advance pulse, registered.
- mode  out  2  0=IDLE, 1=RUN, 2=FAST, 3=HALT.
- halted  out  1  high while in HALT.
- view_code  out  1  display select; toggles on each nowCode press.
- step_count  out  8  count of issued step_en pulses.
- brk_hit  out  1  breakpoint-hit flag.

Behaviour:
- Reset (async, active-high): state IDLE; outputs step_en, mode, halted, view_code, step_count, brk_hit all 0; prescaler and all synchronizer flops cleared.
- Button conditioning:
  - Each button goes through a 2-flop synchronizer plus a delay flop; press = s2 & ~s3.
  - Input high before clock edge k (and held) → press asserted between edges k+1 and k+2.
  - Holding a button produces exactly one press.
- Step latency:
  - next held from edge k → step_en high exactly between edges k+2 and k+3.
  - step_count increments at the same edge step_en rises; wraps 255→0.
- Press priority when several arrive in one cycle: run > speedRun > next. Lower-priority presses in that cycle are discarded.
- State IDLE:
  - next press → one step_en pulse.
  - run press → RUN; speedRun press → FAST. Prescaler cleared on either entry.
- State RUN:
  - Prescaler counts 0..SLOW_DIV-1 and wraps.
  - step_en pulses in the cycle after the prescaler reaches SLOW_DIV-1; first pulse SLOW_DIV clocks after entry.
  - run press → IDLE; speedRun press → FAST with prescaler cleared; next ignored.
- State FAST: identical to RUN but uses FAST_DIV.
  - speedRun press → IDLE; run press → RUN with prescaler cleared.
- DIV=1: step_en high every cycle while in that mode.
- cpu_halt:
  - In IDLE, RUN or FAST → HALT at the next edge; any step_en due that cycle is suppressed.
  - Takes priority over all button presses.
- State HALT:
  - halted=1, no step_en, prescaler held at 0.
  - run press while cpu_halt=0 → IDLE, halted=0. run press while cpu_halt=1 is ignored.
  - next and speedRun ignored.
- view_code toggles on each nowCode press in every state, including HALT.
- Mode changes take effect at the edge after the press; no step_en is issued on that edge.
- Reset asserted mid-operation returns all state immediately to reset values, with no further step_en.

Optional Feature:
- Macro: RUN_CTRL_BREAKPOINT_EN.
- With the macro, in RUN or FAST:
  - When a step_en is due and pc == address, the pulse is suppressed and state → HALT.
  - brk_hit=1 and step_count is not incremented.
  - brk_hit clears when HALT is left.
  - Single-step in IDLE is never blocked.
- Without the macro, pc and address are ignored and brk_hit is tied 0.

Test Plan:
1. Reset, then next high for 5 cycles from edge 10 → step_en high only between edges 12 and 13; step_count=1; mode=0.
2. SLOW_DIV=8, press run → mode=1; step_en every 8 clocks, first pulse 8 clocks after entry; after 4 pulses step_count=4. Press run again → mode=0, no further pulses.
3. FAST_DIV=2, press speedRun from IDLE → pulses every 2 clocks. Press run → mode=1, period 8. Press speedRun → mode=2. Press speedRun again → mode=0.
4. In RUN, assert cpu_halt → mode=3, halted=1, step_en held 0. Press run with cpu_halt=1 → still mode=3. Drop cpu_halt, press run → mode=0, halted=0.
5. In IDLE, press run and next in the same cycle → mode=1, no immediate step_en. Press nowCode twice → view_code 1 then 0. Assert rst mid-RUN → all outputs 0 immediately.
6. With RUN_CTRL_BREAKPOINT_EN, address=0x05, pc=0x05, in RUN with SLOW_DIV=8 → at the first due step: mode=3, brk_hit=1, step_count unchanged. Without the macro, the same stimulus → normal pulses, brk_hit=0.

Source files
------------

// File: rtl/run_controller.sv
`default_nettype none
// =============================================================================
// run_controller : front-panel execution sequencer (single-step / RUN / FAST / HALT)
// Optional breakpoint halt: define RUN_CTRL_BREAKPOINT_EN.   Rev 1.0
// =============================================================================
module run_controller #(
    parameter int DIV_W    = 26,
    parameter int SLOW_DIV = 25000000,
    parameter int FAST_DIV = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       next,
    input  logic       run,
    input  logic       speedRun,
    input  logic       nowCode,
    input  logic       cpu_halt,
    input  logic [7:0] pc,
    input  logic [7:0] address,
    output logic       step_en,
    output logic [1:0] mode,
    output logic       halted,
    output logic       view_code,
    output logic [7:0] step_count,
    output logic       brk_hit
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FAST = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    localparam logic [DIV_W-1:0] c_SLOW_LAST = DIV_W'(SLOW_DIV - 1);
    localparam logic [DIV_W-1:0] c_FAST_LAST = DIV_W'(FAST_DIV - 1);

    state_t           r_state;
    logic [DIV_W-1:0] r_presc;
    logic             r_step_en;
    logic             r_halted;
    logic             r_view_code;
    logic [7:0]       r_step_count;
    logic             r_brk_hit;

    logic [3:0] w_btn;
    logic [3:0] r_s1;
    logic [3:0] r_s2;
    logic [3:0] r_s3;
    logic [3:0] w_press;
    logic       w_press_next;
    logic       w_press_run;
    logic       w_press_fast;
    logic       w_press_code;
    logic       w_last;
    logic       w_bp_match;

    // Bit order: {nowCode, speedRun, run, next}
    assign w_btn   = {nowCode, speedRun, run, next};
    assign w_press = r_s2 & ~r_s3;

    assign w_press_next = w_press[0];
    assign w_press_run  = w_press[1];
    assign w_press_fast = w_press[2];
    assign w_press_code = w_press[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 4'b0;
            r_s2 <= 4'b0;
            r_s3 <= 4'b0;
        end else begin
            r_s1 <= w_btn;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_last = (r_state == ST_FAST) ? (r_presc == c_FAST_LAST)
                                         : (r_presc == c_SLOW_LAST);

`ifdef RUN_CTRL_BREAKPOINT_EN
    assign w_bp_match = (pc == address);
`else
    logic w_unused_bp;
    assign w_unused_bp = ^{pc, address};
    assign w_bp_match  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_presc      <= '0;
            r_step_en    <= 1'b0;
            r_halted     <= 1'b0;
            r_view_code  <= 1'b0;
            r_step_count <= 8'd0;
            r_brk_hit    <= 1'b0;
        end else begin
            r_step_en <= 1'b0;
            if (w_press_code) begin
                r_view_code <= ~r_view_code;
            end

            case (r_state)
                ST_IDLE: begin
                    if (cpu_halt) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                        r_presc  <= '0;
                    end else if (w_press_run) begin
                        r_state <= ST_RUN;
                        r_presc <= '0;
                    end else if (w_press_fast) begin
                        r_state <= ST_FAST;
                        r_presc <= '0;
                    end else if (w_press_next) begin
                        r_step_en    <= 1'b1;
                        r_step_count <= r_step_count + 8'd1;
                    end
                end

                ST_RUN, ST_FAST: begin
                    // Halt and button presses both pre-empt a step due on this edge.
                    if (cpu_halt) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                        r_presc  <= '0;
                    end else if (w_press_run) begin
                        r_state <= (r_state == ST_RUN) ? ST_IDLE : ST_RUN;
                        r_presc <= '0;
                    end else if (w_press_fast) begin
                        r_state <= (r_state == ST_FAST) ? ST_IDLE : ST_FAST;
                        r_presc <= '0;
                    end else if (w_last) begin
                        r_presc <= '0;
                        if (w_bp_match) begin
                            r_state   <= ST_HALT;
                            r_halted  <= 1'b1;
                            r_brk_hit <= 1'b1;
                        end else begin
                            r_step_en    <= 1'b1;
                            r_step_count <= r_step_count + 8'd1;
                        end
                    end else begin
                        r_presc <= r_presc + DIV_W'(1);
                    end
                end

                ST_HALT: begin
                    r_presc <= '0;
                    if (w_press_run && !cpu_halt) begin
                        r_state   <= ST_IDLE;
                        r_halted  <= 1'b0;
                        r_brk_hit <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign step_en    = r_step_en;
    assign mode       = r_state;
    assign halted     = r_halted;
    assign view_code  = r_view_code;
    assign step_count = r_step_count;
    assign brk_hit    = r_brk_hit;

endmodule
`default_nettype wire

// File: tb/tb_run_controller.sv
`default_nettype none
// Directed bench for run_controller with SLOW_DIV=8, FAST_DIV=2.
module tb_run_controller;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       next     = 1'b0;
    logic       run      = 1'b0;
    logic       speedRun = 1'b0;
    logic       nowCode  = 1'b0;
    logic       cpu_halt = 1'b0;
    logic [7:0] pc       = 8'd0;
    logic [7:0] address  = 8'd0;
    logic       step_en;
    logic [1:0] mode;
    logic       halted;
    logic       view_code;
    logic [7:0] step_count;
    logic       brk_hit;

    int checks   = 0;
    int failures = 0;
    int seen;

    always #5 clk = ~clk;

    run_controller #(
        .DIV_W   (4),
        .SLOW_DIV(8),
        .FAST_DIV(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .next      (next),
        .run       (run),
        .speedRun  (speedRun),
        .nowCode   (nowCode),
        .cpu_halt  (cpu_halt),
        .pc        (pc),
        .address   (address),
        .step_en   (step_en),
        .mode      (mode),
        .halted    (halted),
        .view_code (view_code),
        .step_count(step_count),
        .brk_hit   (brk_hit)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mask order {nowCode, speedRun, run, next}; returns at the negedge after the reaction edge.
    task automatic press(input logic [3:0] m);
        wait_neg(1);
        {nowCode, speedRun, run, next} = m;
        wait_neg(3);
        {nowCode, speedRun, run, next} = 4'b0000;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        wait_neg(2);
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_step"},  {7'd0, step_en},   8'd0);
        check({tag, "_mode"},  {6'd0, mode},      8'd0);
        check({tag, "_halt"},  {7'd0, halted},    8'd0);
        check({tag, "_view"},  {7'd0, view_code}, 8'd0);
        check({tag, "_count"}, step_count,        8'd0);
        check({tag, "_brk"},   {7'd0, brk_hit},   8'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        wait_neg(2);
        rst = 1'b0;
        check_all_zero("reset");

        // 1: single step, next held for 5 cycles
        next = 1'b1;
        wait_neg(2);
        check("t1_step_early", {7'd0, step_en}, 8'd0);
        wait_neg(1);
        check("t1_step_pulse", {7'd0, step_en}, 8'd1);
        check("t1_count", step_count, 8'd1);
        wait_neg(1);
        check("t1_step_end", {7'd0, step_en}, 8'd0);
        wait_neg(1);
        next = 1'b0;
        wait_neg(4);
        check("t1_step_held", {7'd0, step_en}, 8'd0);
        check("t1_count_hold", step_count, 8'd1);
        check("t1_mode", {6'd0, mode}, 8'd0);

        // 2: RUN, period 8
        reset_dut();
        press(4'b0010);
        check("t2_mode_run", {6'd0, mode}, 8'd1);
        check("t2_no_entry_step", {7'd0, step_en}, 8'd0);
        for (int p = 0; p < 4; p++) begin
            wait_neg(7);
            check("t2_gap", {7'd0, step_en}, 8'd0);
            wait_neg(1);
            check("t2_pulse", {7'd0, step_en}, 8'd1);
        end
        check("t2_count4", step_count, 8'd4);
        press(4'b0010);
        check("t2_mode_idle", {6'd0, mode}, 8'd0);
        check("t2_stop_step", {7'd0, step_en}, 8'd0);
        seen = 0;
        repeat (20) begin
            wait_neg(1);
            if (step_en) seen++;
        end
        check("t2_idle_pulses", seen[7:0], 8'd0);
        check("t2_count_idle", step_count, 8'd4);

        // 3: FAST period 2, switch to RUN, back to FAST, then off
        press(4'b0100);
        check("t3_mode_fast", {6'd0, mode}, 8'd2);
        check("t3_entry", {7'd0, step_en}, 8'd0);
        wait_neg(1);
        check("t3_gap1", {7'd0, step_en}, 8'd0);
        wait_neg(1);
        check("t3_pulse1", {7'd0, step_en}, 8'd1);
        wait_neg(1);
        check("t3_gap2", {7'd0, step_en}, 8'd0);
        wait_neg(1);
        check("t3_pulse2", {7'd0, step_en}, 8'd1);
        press(4'b0010);
        check("t3_mode_run", {6'd0, mode}, 8'd1);
        check("t3_switch_nostep", {7'd0, step_en}, 8'd0);
        check("t3_count7", step_count, 8'd7);
        wait_neg(7);
        check("t3_run_gap", {7'd0, step_en}, 8'd0);
        wait_neg(1);
        check("t3_run_pulse", {7'd0, step_en}, 8'd1);
        check("t3_count8", step_count, 8'd8);
        press(4'b0100);
        check("t3_mode_fast2", {6'd0, mode}, 8'd2);
        press(4'b0100);
        check("t3_mode_idle", {6'd0, mode}, 8'd0);
        check("t3_off_nostep", {7'd0, step_en}, 8'd0);
        check("t3_count9", step_count, 8'd9);

        // 4: halt arrives on the same edge a RUN step is due
        press(4'b0010);
        check("t4_mode_run", {6'd0, mode}, 8'd1);
        wait_neg(7);
        cpu_halt = 1'b1;
        wait_neg(1);
        check("t4_mode_halt", {6'd0, mode}, 8'd3);
        check("t4_halted", {7'd0, halted}, 8'd1);
        check("t4_suppressed", {7'd0, step_en}, 8'd0);
        check("t4_count", step_count, 8'd9);
        press(4'b0010);
        check("t4_run_ignored", {6'd0, mode}, 8'd3);
        press(4'b0101);
        check("t4_buttons_ignored", {6'd0, mode}, 8'd3);
        check("t4_count_halt", step_count, 8'd9);
        press(4'b1000);
        check("t4_view_in_halt", {7'd0, view_code}, 8'd1);
        cpu_halt = 1'b0;
        press(4'b0010);
        check("t4_mode_idle", {6'd0, mode}, 8'd0);
        check("t4_unhalted", {7'd0, halted}, 8'd0);

        // 5: run+next together, view toggles, reset mid-RUN
        press(4'b0011);
        check("t5_mode_run", {6'd0, mode}, 8'd1);
        check("t5_next_discarded", {7'd0, step_en}, 8'd0);
        check("t5_count", step_count, 8'd9);
        press(4'b1000);
        check("t5_view0", {7'd0, view_code}, 8'd0);
        press(4'b1000);
        check("t5_view1", {7'd0, view_code}, 8'd1);
        check("t5_still_run", {6'd0, mode}, 8'd1);
        wait_neg(2);
        rst = 1'b1;
        #1;
        check_all_zero("t5_async_rst");
        wait_neg(3);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            wait_neg(1);
            if (step_en) seen++;
        end
        check("t5_no_pulses_after_rst", seen[7:0], 8'd0);
        check("t5_mode_after_rst", {6'd0, mode}, 8'd0);

        // 6: breakpoint at pc == address
        pc      = 8'h05;
        address = 8'h05;
        press(4'b0010);
        wait_neg(7);
        check("t6_gap", {7'd0, step_en}, 8'd0);
        wait_neg(1);
`ifdef RUN_CTRL_BREAKPOINT_EN
        check("t6_mode", {6'd0, mode}, 8'd3);
        check("t6_brk", {7'd0, brk_hit}, 8'd1);
        check("t6_step", {7'd0, step_en}, 8'd0);
        check("t6_halted", {7'd0, halted}, 8'd1);
        check("t6_count", step_count, 8'd0);
`else
        check("t6_mode", {6'd0, mode}, 8'd1);
        check("t6_brk", {7'd0, brk_hit}, 8'd0);
        check("t6_step", {7'd0, step_en}, 8'd1);
        check("t6_halted", {7'd0, halted}, 8'd0);
        check("t6_count", step_count, 8'd1);
`endif
        press(4'b0010);
        check("t6_mode_idle", {6'd0, mode}, 8'd0);
        check("t6_brk_clear", {7'd0, brk_hit}, 8'd0);
        check("t6_halted_clear", {7'd0, halted}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
